// File: rtl/rfphoenix_vec_lane_gather_if.sv
// Handshake and data bus of the vector lane-gather engine: scalar beat input,
// base-vector seed and flush on one side, assembled-vector output on the other.
interface rfphoenix_vec_lane_gather_if #(
    parameter int NLANES = 16,
    parameter int WID    = 32,
    parameter int LIDX   = 4
);
    logic                   flush;
    logic [NLANES*WID-1:0]  base_vec;
    logic                   in_valid;
    logic                   in_ready;
    logic [LIDX-1:0]        in_lane;
    logic [WID-1:0]         in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [NLANES*WID-1:0]  out_vec;
    logic [NLANES-1:0]      out_mask;
    logic                   out_err;

    modport master (
        output flush, base_vec, in_valid, in_lane, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, out_mask, out_err
    );

    modport slave (
        input  flush, base_vec, in_valid, in_lane, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, out_mask, out_err
    );
endinterface

// File: rtl/rfphoenix_vec_lane_gather.sv
// Sequential lane-insert engine: folds scalar (lane, value) beats into a vector
// seeded from base_vec and hands the result on with a valid/ready handshake.
module rfphoenix_vec_lane_gather #(
    parameter int NLANES = 16,
    parameter int WID    = 32,
    parameter int LIDX   = 4
) (
    input  logic clk,
    input  logic rst_n,
    rfphoenix_vec_lane_gather_if.slave bus
);
    localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t                       state_q, state_d;
    logic [NLANES-1:0][WID-1:0]   work_q, work_d;
    logic [NLANES-1:0]            mask_q, mask_d;
    logic                         err_q, err_d;
    logic                         first_q;
    logic                         in_ready, out_valid;
    logic                         accept, lane_ok, done;
    logic [LW-1:0]                lane_idx;

    assign accept   = bus.in_valid & in_ready;
    assign lane_ok  = (32'(bus.in_lane) < NLANES);
    assign lane_idx = bus.in_lane[LW-1:0];

    // Beat datapath: the first beat of a gather starts from base_vec instead of the held vector.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        work_d = first_q ? bus.base_vec : work_q;
        mask_d = mask_q;
        err_d  = err_q;
        if (lane_ok) begin
            work_d[lane_idx] = bus.in_data;
            mask_d[lane_idx] = 1'b1;
        end else begin
            err_d = 1'b1;
        end
    end

    assign done = accept & (bus.in_last | (&mask_d));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n)          state_q <= COLLECT;
        else if (bus.flush)  state_q <= COLLECT;
        else                 state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (done)          state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = COLLECT;
            default:                    state_d = COLLECT;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == HOLD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the working vector is wide but still reset, because out_vec must read zero after reset.
            work_q  <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (bus.flush) begin
            mask_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end else if (accept) begin
            work_q  <= work_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            first_q <= 1'b0;
        end else if (out_valid && bus.out_ready) begin
            mask_q  <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_vec   = work_q;
    assign bus.out_mask  = mask_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_rfphoenix_vec_lane_gather.sv
// Directed bench for the lane-gather engine: a table of beats with hand-computed
// results, plus hand-written hold, back-pressure, flush and reset sequences.
module tb_rfphoenix_vec_lane_gather;
    localparam int NL = 16;
    localparam int W  = 32;
    localparam int LI = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rfphoenix_vec_lane_gather_if #(.NLANES(NL), .WID(W), .LIDX(LI)) bus ();

    rfphoenix_vec_lane_gather #(.NLANES(NL), .WID(W), .LIDX(LI)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [LI-1:0] lane;
        logic [W-1:0]  data;
        logic          last;
        logic          exp_valid;
        logic [NL-1:0] exp_mask;
        logic          exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] base_m [NL];
    logic [W-1:0] exp_v  [NL];
    logic         tb_first;
    vec_t         tbl [9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_base(input bit zero);
        for (int n = 0; n < NL; n++) begin
            base_m[n] = zero ? 32'h0 : 32'hA0 + 32'(n);
            bus.base_vec[n*W +: W] = base_m[n];
        end
    endtask

    task automatic beat(input logic [LI-1:0] lane, input logic [W-1:0] data, input logic last);
        bus.in_valid = 1'b1;
        bus.in_lane  = lane;
        bus.in_data  = data;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic check_lanes(input string name);
        for (int n = 0; n < NL; n++)
            check($sformatf("%s lane%0d", name, n), 64'(bus.out_vec[n*W +: W]), 64'(exp_v[n]));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{5'd3,  32'hDEADBEEF, 1'b1, 1'b1, 16'h0008, 1'b0};
        tbl[1] = '{5'd20, 32'h7,        1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{5'd0,  32'h9,        1'b1, 1'b1, 16'h0001, 1'b1};
        tbl[3] = '{5'd7,  32'h77,       1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[4] = '{5'd15, 32'hFF,       1'b1, 1'b1, 16'h8080, 1'b0};
        tbl[5] = '{5'd31, 32'h1,        1'b1, 1'b1, 16'h0000, 1'b1};
        tbl[6] = '{5'd16, 32'h5,        1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[7] = '{5'd15, 32'h6,        1'b1, 1'b1, 16'h8000, 1'b1};
        tbl[8] = '{5'd9,  32'h99,       1'b1, 1'b1, 16'h0200, 1'b0};

        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_lane = '0;
        bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        set_base(1'b0);

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_mask",  64'(bus.out_mask),  64'd0);
        check("reset out_err",   64'(bus.out_err),   64'd0);
        check("reset out_vec",   64'(bus.out_vec[63:0]), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

        // Table-driven beats; the lane model follows seed-then-insert semantics
        tb_first = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (tb_first) for (int n = 0; n < NL; n++) exp_v[n] = base_m[n];
            tb_first = 1'b0;
            if (32'(tbl[i].lane) < NL) exp_v[tbl[i].lane[3:0]] = tbl[i].data;
            beat(tbl[i].lane, tbl[i].data, tbl[i].last);
            check($sformatf("tbl%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d in_ready", i),  64'(bus.in_ready),  64'(!tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d out_mask", i), 64'(bus.out_mask), 64'(tbl[i].exp_mask));
                check($sformatf("tbl%0d out_err", i),  64'(bus.out_err),  64'(tbl[i].exp_err));
                check_lanes($sformatf("tbl%0d", i));
                consume();
                check($sformatf("tbl%0d ready after consume", i), 64'(bus.in_ready), 64'd1);
                check($sformatf("tbl%0d valid after consume", i), 64'(bus.out_valid), 64'd0);
                tb_first = 1'b1;
            end
        end

        // Full gather without last: early completion on mask all ones
        for (int n = 0; n < NL; n++) begin
            exp_v[n] = 32'(n) * 32'h11;
            beat(LI'(n), exp_v[n], 1'b0);
            if (n < NL - 1) check($sformatf("full beat%0d out_valid", n), 64'(bus.out_valid), 64'd0);
        end
        check("full out_valid", 64'(bus.out_valid), 64'd1);
        check("full out_mask",  64'(bus.out_mask),  64'hFFFF);
        check("full in_ready",  64'(bus.in_ready),  64'd0);
        bus.in_valid = 1'b1; bus.in_lane = 5'd0; bus.in_data = 32'h999; bus.in_last = 1'b1;
        tick(); tick();
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        check("full hold in_ready", 64'(bus.in_ready), 64'd0);
        check_lanes("full hold");
        consume();

        // Duplicate lane with back-pressure
        for (int n = 0; n < NL; n++) exp_v[n] = base_m[n];
        exp_v[5] = 32'h2;
        beat(5'd5, 32'h1, 1'b0);
        beat(5'd5, 32'h2, 1'b1);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("dup hold%0d out_valid", c), 64'(bus.out_valid), 64'd1);
            check($sformatf("dup hold%0d lane5", c), 64'(bus.out_vec[5*W +: W]), 64'h2);
            check($sformatf("dup hold%0d out_mask", c), 64'(bus.out_mask), 64'h0020);
            tick();
        end
        check_lanes("dup");
        consume();
        check("dup in_ready after consume", 64'(bus.in_ready), 64'd1);

        // Flush mid-gather drops the partial vector and the same-cycle beat
        beat(5'd1, 32'h11, 1'b0);
        beat(5'd2, 32'h22, 1'b0);
        bus.flush = 1'b1;
        beat(5'd3, 32'h33, 1'b0);
        bus.flush = 1'b0;
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        set_base(1'b1);
        for (int n = 0; n < NL; n++) exp_v[n] = 32'h0;
        exp_v[4] = 32'h44;
        beat(5'd4, 32'h44, 1'b1);
        check("flush gather out_valid", 64'(bus.out_valid), 64'd1);
        check("flush gather out_mask",  64'(bus.out_mask),  64'h0010);
        check("flush gather out_err",   64'(bus.out_err),   64'd0);
        check_lanes("flush");
        consume();

        // Reset while holding a vector
        set_base(1'b0);
        beat(5'd0, 32'h5, 1'b1);
        check("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("hold-reset out_valid", 64'(bus.out_valid), 64'd0);
        check("hold-reset out_mask",  64'(bus.out_mask),  64'd0);
        check("hold-reset out_err",   64'(bus.out_err),   64'd0);
        check("hold-reset in_ready",  64'(bus.in_ready),  64'd1);
        check("hold-reset lane0",     64'(bus.out_vec[W-1:0]), 64'd0);
        for (int n = 0; n < NL; n++) exp_v[n] = base_m[n];
        exp_v[2] = 32'h22;
        beat(5'd2, 32'h22, 1'b1);
        check("reseed out_valid", 64'(bus.out_valid), 64'd1);
        check("reseed out_mask",  64'(bus.out_mask),  64'h0004);
        check_lanes("reseed");
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
